// File: rtl/cam_capture_wr.sv
// Camera byte-stream to RGB565 write initiator for the ping-pong input frame buffer.
// Optional build macro CAM_BYTE_SWAP_EN: first byte of each pixel is the low byte.
module cam_capture_wr #(
    parameter int H_ACT  = 480,
    parameter int V_ACT  = 272,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_en,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_data,
    output logic              o_cam_vsync,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_frame_done,
    output logic              o_err
);

    localparam int COL_W  = $clog2(H_ACT + 1);
    localparam int LINE_W = $clog2(V_ACT + 1);
    localparam logic [COL_W-1:0]  COL_LIM   = COL_W'(H_ACT);
    localparam logic [LINE_W-1:0] LINE_LIM  = LINE_W'(V_ACT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACT);

    typedef enum logic [1:0] {
        WAIT_VS,
        BLANK,
        LINE
    } state_t;

    state_t              state;
    logic                vs_prev;
    logic                phase;
    logic                wrote_any;
    logic [7:0]          byte0;
    logic [COL_W-1:0]    col;
    logic [LINE_W-1:0]   line;
    logic [ADDR_W-1:0]   line_base;
    logic                vs_rise;
    logic                vs_fall;
    logic                href_valid;
    logic [15:0]         pixel;

    // Edges are judged between successive strobes, not successive clocks.
    assign vs_rise    = i_pix_en & i_vsync & ~vs_prev;
    assign vs_fall    = i_pix_en & ~i_vsync & vs_prev;
    assign href_valid = i_pix_en & i_href & ~i_vsync;

    always_comb begin
        pixel = '0;
`ifdef CAM_BYTE_SWAP_EN
        pixel = {i_data, byte0};
`else
        pixel = {byte0, i_data};
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= WAIT_VS;
            vs_prev      <= 1'b0;
            phase        <= 1'b0;
            wrote_any    <= 1'b0;
            byte0        <= '0;
            col          <= '0;
            line         <= '0;
            line_base    <= '0;
            o_cam_vsync  <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_cam_vsync  <= i_vsync;
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_pix_en) begin
                vs_prev <= i_vsync;
                case (state)
                    WAIT_VS: begin
                        if (vs_fall) begin
                            state     <= BLANK;
                            col       <= '0;
                            line      <= '0;
                            line_base <= '0;
                            phase     <= 1'b0;
                            wrote_any <= 1'b0;
                        end
                    end
                    BLANK: begin
                        if (vs_rise) begin
                            o_frame_done <= wrote_any;
                            state        <= WAIT_VS;
                        end else if (href_valid) begin
                            byte0 <= i_data;
                            phase <= 1'b1;
                            state <= LINE;
                        end
                    end
                    LINE: begin
                        if (vs_rise) begin
                            // A frame cut short mid-line is always reported as malformed.
                            o_err        <= 1'b1;
                            phase        <= 1'b0;
                            o_frame_done <= wrote_any;
                            state        <= WAIT_VS;
                        end else if (href_valid) begin
                            if (!phase) begin
                                byte0 <= i_data;
                                phase <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (col < COL_LIM && line < LINE_LIM) begin
                                    o_wr_en   <= 1'b1;
                                    o_wr_addr <= line_base + ADDR_W'(col);
                                    o_wr_data <= DATA_W'(pixel);
                                    col       <= col + 1'b1;
                                    wrote_any <= 1'b1;
                                end else begin
                                    o_err <= 1'b1;
                                end
                            end
                        end else begin
                            // Line base always steps a full line so short lines never shift later ones.
                            if (phase) begin
                                o_err <= 1'b1;
                            end
                            phase <= 1'b0;
                            col   <= '0;
                            if (line < LINE_LIM) begin
                                line      <= line + 1'b1;
                                line_base <= line_base + LINE_STEP;
                            end
                            state <= BLANK;
                        end
                    end
                    default: state <= WAIT_VS;
                endcase
            end
        end
    end

endmodule
